// File: rtl/font5x7_beep_seq.sv
// Square-wave melody sounder: a start request plays one of four fixed 4-note
// melodies (tone then silent gap per note) on SOUND_o, with BUSY_o/DONE_o status.
module font5x7_beep_seq #(
    parameter int unsigned C_F_CK    = 130_000_000,
    parameter int unsigned C_NOTE_MS = 100,
    parameter int unsigned C_GAP_MS  = 20
) (
    input  logic       CK_i,
    input  logic       XARST_i,
    input  logic       START_i,
    input  logic [1:0] PATTERN_i,
    input  logic       MUTE_i,
    output logic       BUSY_o,
    output logic       DONE_o,
    output logic       SOUND_o
);

    function automatic int unsigned clog2_f(input int unsigned v);
        int unsigned r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    localparam int unsigned NOTE_CYC = C_F_CK / 1000 * C_NOTE_MS;
    localparam int unsigned GAP_CYC  = C_F_CK / 1000 * C_GAP_MS;
    localparam int unsigned HP_C5    = C_F_CK / (2 * 523);
    localparam int unsigned HP_E5    = C_F_CK / (2 * 659);
    localparam int unsigned HP_G5    = C_F_CK / (2 * 784);
    localparam int unsigned HP_C6    = C_F_CK / (2 * 1047);
    localparam int unsigned DUR_MAX  = (NOTE_CYC > GAP_CYC) ? NOTE_CYC : GAP_CYC;
    localparam int unsigned DUR_W    = clog2_f(DUR_MAX);
    localparam int unsigned HP_W     = clog2_f(HP_C5);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TONE = 2'd1,
        S_GAP  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    // Note codes: 0=REST, 1=C5, 2=E5, 3=G5, 4=C6
    function automatic logic [2:0] note_sel(input logic [1:0] pat, input logic [1:0] idx);
        logic [2:0] n;
        case ({pat, idx})
            4'b00_00: n = 3'd1;
            4'b00_01: n = 3'd2;
            4'b00_10: n = 3'd3;
            4'b00_11: n = 3'd4;
            4'b01_00: n = 3'd4;
            4'b01_01: n = 3'd3;
            4'b01_10: n = 3'd2;
            4'b01_11: n = 3'd1;
            4'b10_00: n = 3'd1;
            4'b10_01: n = 3'd0;
            4'b10_10: n = 3'd1;
            4'b10_11: n = 3'd0;
            4'b11_00: n = 3'd3;
            4'b11_01: n = 3'd3;
            4'b11_10: n = 3'd3;
            4'b11_11: n = 3'd4;
            default:  n = 3'd0;
        endcase
        return n;
    endfunction

    // REST keeps the half-period counter running on the C5 period; its output is masked anyway.
    function automatic logic [HP_W-1:0] hp_last(input logic [2:0] note);
        logic [HP_W-1:0] h;
        case (note)
            3'd1:    h = HP_W'(HP_C5 - 1);
            3'd2:    h = HP_W'(HP_E5 - 1);
            3'd3:    h = HP_W'(HP_G5 - 1);
            3'd4:    h = HP_W'(HP_C6 - 1);
            default: h = HP_W'(HP_C5 - 1);
        endcase
        return h;
    endfunction

    state_t           state_q, state_d;
    logic [1:0]       pat_q, pat_d;
    logic [1:0]       note_q, note_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic [HP_W-1:0]  hp_q, hp_d;
    logic             phase_q, phase_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             sound_q, sound_d;

    // State, datapath and output registers
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            state_q <= S_IDLE;
            pat_q   <= 2'd0;
            note_q  <= 2'd0;
            dur_q   <= '0;
            hp_q    <= '0;
            phase_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sound_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            note_q  <= note_d;
            dur_q   <= dur_d;
            hp_q    <= hp_d;
            phase_q <= phase_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sound_q <= sound_d;
        end
    end

    // Next-state and sequencing counters
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        note_d  = note_q;
        dur_d   = dur_q;
        hp_d    = hp_q;
        phase_d = phase_q;
        case (state_q)
            S_IDLE: begin
                if (START_i) begin
                    state_d = S_TONE;
                    pat_d   = PATTERN_i;
                    note_d  = 2'd0;
                    dur_d   = '0;
                    hp_d    = '0;
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                end
            end
            S_TONE: begin
                if (dur_q == DUR_W'(NOTE_CYC - 1)) begin
                    state_d = S_GAP;
                    dur_d   = '0;
                    hp_d    = '0;
                    phase_d = 1'b0;
                end else begin
                    dur_d = dur_q + DUR_W'(1);
                    if (hp_q == hp_last(note_sel(pat_q, note_q))) begin
                        hp_d    = '0;
                        phase_d = ~phase_q;
                    end else begin
                        hp_d = hp_q + HP_W'(1);
                    end
                end
            end
            S_GAP: begin
                phase_d = 1'b0;
                if (dur_q == DUR_W'(GAP_CYC - 1)) begin
                    dur_d = '0;
                    if (note_q == 2'd3) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_TONE;
                        note_d  = note_q + 2'd1;
                        hp_d    = '0;
                        phase_d = 1'b1;
                    end
                end else begin
                    dur_d = dur_q + DUR_W'(1);
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                dur_d   = '0;
                phase_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                dur_d   = '0;
                hp_d    = '0;
                phase_d = 1'b0;
            end
        endcase
    end

    // Outputs are computed from the next state so they line up with it once registered
    always_comb begin
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_FIN);
        sound_d = phase_d & (state_d == S_TONE)
                & (note_sel(pat_d, note_d) != 3'd0) & ~MUTE_i;
    end

    assign BUSY_o  = busy_q;
    assign DONE_o  = done_q;
    assign SOUND_o = sound_q;

endmodule
